// File: rtl/jogo_pkg.sv
// Shared game constants: FSM state encoding, screen geometry and spawn helpers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package jogo_pkg;

    // Fire-controller state encoding, fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        PRONTO  = 2'd0,
        DISPARO = 2'd1,
        VOO     = 2'd2,
        RECARGA = 2'd3
    } estado_t;

    // Visible screen size in pixels.
    localparam int LARGURA_TELA  = 640;
    localparam int ALTURA_TELA   = 480;

    // Projectile y at/above this value is off-screen.
    localparam int Y_LIMITE_TELA = ALTURA_TELA;

    // Vertical offset the projectile block subtracts from the spawn y.
    localparam int OFFSET_Y      = 35;

    // Horizontal centre of the shooter, wrapping at 10 bits.
    function automatic logic [9:0] centro_x(input logic [9:0] x, input logic [9:0] largura);
        return x + (largura >> 1);
    endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Brings an asynchronous level into core_clk domain and emits one pulse per rising edge.
// Latency: pulse is high 3 cycles after the raw rising edge (2 sync FFs + registered edge detect).
// Backpressure: none; a held input produces a single pulse, a new pulse needs the input to drop first.
module sincroniza_borda (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    logic sinc_1;
    logic sinc_2;
    logic sinc_ant;

    // Two-flop synchronizer, a delayed copy for edge detection and a registered pulse.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sinc_1   <= 1'b0;
            sinc_2   <= 1'b0;
            sinc_ant <= 1'b0;
            pulso    <= 1'b0;
        end else begin
            sinc_1   <= entrada;
            sinc_2   <= sinc_1;
            sinc_ant <= sinc_2;
            pulso    <= sinc_2 & ~sinc_ant;
        end
    end

endmodule

// File: rtl/controle_disparo.sv
// Fire controller: turns the fire button into a bola_reset spawn pulse with latched xi/yi, tracks the flight, cooldown, ammo and hits.
// Latency: bola_reset rises 4 cycles after the raw button edge; flight end is seen 2 cycles after yBola/colisao change.
// Backpressure: none; presses outside PRONTO, while paused or without ammo are dropped. Macro MUNICAO_LIMITADA_EN enables the ammo limit.
module controle_disparo
    import jogo_pkg::*;
#(
    parameter int COOLDOWN_CYC = 25_000_000,
    parameter int RESET_PULSE  = 4,
    parameter int MUNICAO_MAX  = 9,
    parameter int Y_LIMITE     = Y_LIMITE_TELA
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic       botao_disparo,
    input  logic [9:0] xAtirador,
    input  logic [9:0] yAtirador,
    input  logic [9:0] larguraAtirador,
    input  logic [9:0] yBola,
    input  logic       colisao,
    output logic       bola_reset,
    output logic [9:0] xi,
    output logic [9:0] yi,
    output logic       em_voo,
    output logic [3:0] municao,
    output logic [7:0] acertos
);

    localparam int PW = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
    localparam int CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

    localparam logic [PW-1:0] PULSO_ULT   = PW'(RESET_PULSE - 1);
    localparam logic [CW-1:0] RECARGA_ULT = CW'(COOLDOWN_CYC - 1);
    localparam logic [9:0]    Y_LIM       = 10'(Y_LIMITE);
    localparam logic [3:0]    MUN_CHEIA   = 4'(MUNICAO_MAX);

    estado_t       estado;
    estado_t       estado_nxt;
    logic          pedido;
    logic          disparar;
    logic          acerto;
    logic          tem_municao;
    logic [9:0]    y_bola_q;
    logic          colisao_q;
    logic [PW-1:0] cnt_pulso;
    logic [CW-1:0] cnt_recarga;

    sincroniza_borda u_botao (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .entrada  (botao_disparo),
        .pulso    (pedido)
    );

    // Spawn pulse and flight flag decode straight from the state, so async reset clears them at once.
    assign bola_reset = (estado == DISPARO);
    assign em_voo     = (estado == VOO);

`ifdef MUNICAO_LIMITADA_EN
    logic [3:0] municao_q;

    // Ammo: refilled on restart, one round spent per accepted shot; never fires at zero so it cannot underflow.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            municao_q <= MUN_CHEIA;
        end else if (reiniciarJogo) begin
            municao_q <= MUN_CHEIA;
        end else if (disparar) begin
            municao_q <= municao_q - 4'd1;
        end
    end

    assign municao     = municao_q;
    assign tem_municao = (municao_q != 4'd0);
`else
    assign municao     = MUN_CHEIA;
    assign tem_municao = 1'b1;
`endif

    // Next-state and event decode; restart overrides everything.
    always_comb begin
        estado_nxt = estado;
        disparar   = 1'b0;
        acerto     = 1'b0;
        case (estado)
            PRONTO: begin
                if (pedido && !pausa && tem_municao) begin
                    disparar   = 1'b1;
                    estado_nxt = DISPARO;
                end
            end
            DISPARO: begin
                if (cnt_pulso == PULSO_ULT) begin
                    estado_nxt = VOO;
                end
            end
            VOO: begin
                // A hit wins over leaving the screen in the same cycle.
                if (!pausa && (colisao_q || (y_bola_q >= Y_LIM))) begin
                    acerto     = colisao_q;
                    estado_nxt = RECARGA;
                end
            end
            RECARGA: begin
                if (!pausa && (cnt_recarga == RECARGA_ULT)) begin
                    estado_nxt = PRONTO;
                end
            end
            default: estado_nxt = PRONTO;
        endcase
        if (reiniciarJogo) begin
            estado_nxt = PRONTO;
            disparar   = 1'b0;
            acerto     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            estado <= PRONTO;
        end else begin
            estado <= estado_nxt;
        end
    end

    // One register each on the projectile y and the collision flag before they are used.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            y_bola_q  <= '0;
            colisao_q <= 1'b0;
        end else begin
            y_bola_q  <= yBola;
            colisao_q <= colisao;
        end
    end

    // Pulse-width and cooldown counters; both restart from zero whenever their state is left.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_pulso   <= '0;
            cnt_recarga <= '0;
        end else begin
            cnt_pulso <= (estado == DISPARO && estado_nxt == DISPARO) ? cnt_pulso + PW'(1) : '0;
            if (estado == RECARGA && estado_nxt == RECARGA) begin
                if (!pausa) begin
                    cnt_recarga <= cnt_recarga + CW'(1);
                end
            end else begin
                cnt_recarga <= '0;
            end
        end
    end

    // Spawn position is captured on the accepted shot and held until the next one (kept across restart).
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            xi <= '0;
            yi <= '0;
        end else if (disparar) begin
            xi <= centro_x(xAtirador, larguraAtirador);
            yi <= yAtirador;
        end
    end

    // Saturating hit counter for the scoreboard.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            acertos <= '0;
        end else if (reiniciarJogo) begin
            acertos <= '0;
        end else if (acerto && (acertos != 8'hFF)) begin
            acertos <= acertos + 8'd1;
        end
    end

endmodule

// File: doc/controle_disparo.md
Name: controle_disparo

Overview:
- Fire controller that sits directly upstream of the projectile block.
- Turns the player's fire button into a spawn command for the projectile: an active-high `bola_reset` pulse plus a latched spawn position `xi`/`yi`.
- Tracks the shot in flight until it leaves the screen or hits a target, then enforces a cooldown.
- Manages a limited ammo count and a hit counter for the scoreboard.

Parameters:
- `COOLDOWN_CYC`, 25_000_000, CLOCK_50 cycles in RECARGA after a flight ends (0.5 s).
- `RESET_PULSE`, 4, width in cycles of the `bola_reset` pulse (must be ≥1).
- `MUNICAO_MAX`, 9, ammo loaded at reset/restart (max 15).
- `Y_LIMITE`, 480, `yBola` value at/above which the shot counts as off-screen.

Ports:
- `CLOCK_50` input 1 50 MHz system clock
- `reset` input 1 asynchronous, active-high
- `pausa` input 1 game paused
- `reiniciarJogo` input 1 synchronous restart, level
- `botao_disparo` input 1 raw fire button, active-high, asynchronous
- `xAtirador` input 10 shooter left x
- `yAtirador` input 10 shooter top y
- `larguraAtirador` input 10 shooter width
- `yBola` input 10 current projectile y (from the projectile block)
- `colisao` input 1 projectile hit a target (from the collision block), level
- `bola_reset` output 1 spawn pulse to the projectile block
- `xi` output 10 latched spawn x
- `yi` output 10 latched spawn y
- `em_voo` output 1 shot currently in flight
- `municao` output 4 remaining ammo
- `acertos` output 8 hit count, saturating

Behaviour:
- Reset is asynchronous, active-high, clock is CLOCK_50. Reset values:
  - state = PRONTO
  - `bola_reset` = 0, `em_voo` = 0
  - `xi` = 0, `yi` = 0
  - `municao` = `MUNICAO_MAX`, `acertos` = 0
  - synchronizer and counters cleared
- Input conditioning:
  - `botao_disparo` passes through a 2-FF synchronizer, then a rising-edge detector.
  - Resulting one-cycle `pedido` occurs 3 cycles after the raw rising edge.
  - A held button produces exactly one `pedido`.
- Registered sampling:
  - `yBola` and `colisao` are sampled through one register each before use.
  - `yBola` changes slowly relative to CLOCK_50, so single-register sampling is sufficient.
- State PRONTO:
  - On `pedido` && !`pausa` && `municao` ≠ 0: go to DISPARO.
  - Same cycle: `xi` ← `xAtirador` + (`larguraAtirador` >> 1), 10-bit wrap; `yi` ← `yAtirador`; `municao` decrements.
  - A `pedido` that does not meet these conditions is discarded.
- State DISPARO:
  - `bola_reset` = 1 for exactly `RESET_PULSE` cycles, then go to VOO.
  - `xi`/`yi` stay stable from the first DISPARO cycle until the next fire.
- State VOO:
  - `em_voo` = 1.
  - Flight ends when registered `colisao` = 1 or registered `yBola` ≥ `Y_LIMITE`; then go to RECARGA.
  - If the end was caused by `colisao`, `acertos` increments and saturates at 255.
  - If both end conditions occur in the same cycle: a single flight end, counted as a hit.
  - `pedido` is ignored.
  - `pausa` freezes the state (no end detection while paused).
- State RECARGA:
  - Counter runs from 0 to `COOLDOWN_CYC`-1, then go to PRONTO.
  - `pausa` holds the counter.
  - `pedido` is discarded.
- Boundary conditions:
  - `yAtirador` < 35 makes the projectile's spawn y wrap to ≥480, so the flight ends on the first VOO evaluation; this is legal and costs one ammo.
  - `municao` never underflows; with `municao` = 0 the block stays in PRONTO.
- `reiniciarJogo` = 1 (synchronous, highest priority after reset):
  - state = PRONTO, `municao` = `MUNICAO_MAX`, `acertos` = 0, `bola_reset` = 0, counters cleared.
  - `xi`/`yi` are retained.
- Async reset mid-flight or mid-pulse: `bola_reset` drops immediately and all outputs take their reset values.

Optional Feature:
- Macro `MUNICAO_LIMITADA_EN`.
- Defined: ammo logic exactly as above.
- Undefined:
  - `municao` is held constant at `MUNICAO_MAX`.
  - The `municao` ≠ 0 fire condition is removed (unlimited shots).
  - Decrement and refill logic is not synthesized.

Decomposition:
- Shared package `jogo_pkg`:
  - State encoding constants PRONTO=2'd0, DISPARO=2'd1, VOO=2'd2, RECARGA=2'd3.
  - `Y_LIMITE`/screen size constants 640×480.
  - Offset 35 shared with the projectile block.
- One natural sub-module: `sincroniza_borda` (2-FF synchronizer + rising-edge detector, 1-bit in, 1-cycle pulse out). Reusable for other buttons.

Test Plan:
- Sim parameters: `COOLDOWN_CYC`=8, `RESET_PULSE`=2, `MUNICAO_MAX`=3.
- Single shot: press the button with `xAtirador`=100, `larguraAtirador`=40, `yAtirador`=440 → `bola_reset` high on cycles 4–5 after press; `xi`=120, `yi`=440; `municao`=2; then `em_voo`=1.
- Off-screen end: in VOO drive `yBola`=479 → no change; `yBola`=480 → `em_voo` drops 2 cycles later; PRONTO after 8 more cycles; `acertos`=0.
- Hit plus simultaneous edge: `colisao`=1 and `yBola`=480 in the same cycle → `acertos`=1 (once); a button press during RECARGA → no `bola_reset`.
- Ammo exhaustion: 3 complete shots then a 4th press → no `bola_reset`, `municao`=0; pulse `reiniciarJogo` → `municao`=3.
- Pause: `pausa`=1 during RECARGA for 20 cycles → PRONTO is reached 20 cycles later than nominal; a press while paused in PRONTO → ignored.
- Async reset: assert `reset` during the DISPARO pulse → `bola_reset`=0 immediately; `municao`=3, `acertos`=0.
